// File: rtl/nn_pkg.sv
// nn_pkg: types and constants shared by the weight memory blocks.
//   state_e  - load FSM state (idle / streaming load / load complete)
//   BitSize  - default weight word width
//   weight_t - one weight word at the default width
package nn_pkg;

  localparam int unsigned BitSize = 16;

  typedef logic [BitSize-1:0] weight_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/weight_bank_loader_if.sv
// weight_bank_loader_if: load stream and layer read port of the weight bank.
//   start / in_valid / in_ready / in_data : word stream into the bank
//   busy / load_done                      : load status
//   rd_en / rd_layer / rd_data / rd_valid  : whole-layer registered read port
// master drives requests (producer / MAC array side), slave is the bank.
interface weight_bank_loader_if #(
  parameter int unsigned LAYER_SIZE  = 4,
  parameter int unsigned LAYER_DEPTH = 4,
  parameter int unsigned BIT_SIZE    = 16
) ();

  logic                                 start;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [BIT_SIZE-1:0]                  in_data;
  logic                                 busy;
  logic                                 load_done;
  logic                                 rd_en;
  logic [$clog2(LAYER_DEPTH)-1:0]       rd_layer;
  logic [LAYER_SIZE-1:0][BIT_SIZE-1:0]  rd_data;
  logic                                 rd_valid;

  modport master (
    output start, in_valid, in_data, rd_en, rd_layer,
    input  in_ready, busy, load_done, rd_data, rd_valid
  );

  modport slave (
    input  start, in_valid, in_data, rd_en, rd_layer,
    output in_ready, busy, load_done, rd_data, rd_valid
  );

endinterface

// File: rtl/weight_lane.sv
// weight_lane: one node's weight storage, Depth x Width.
//   clk, reset        : clock, synchronous active-high reset (read register only)
//   i_we/i_waddr/i_wdata : single write port
//   i_re/i_raddr      : read request
//   o_rdata           : registered read data, holds when i_re is low
// A read and write to the same address in one cycle returns the old word.
module weight_lane #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [$clog2(Depth)-1:0] i_waddr,
  input  logic [Width-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(Depth)-1:0] i_raddr,
  output logic [Width-1:0]         o_rdata
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rdata;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Non-blocking read of the array sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/weight_bank_loader.sv
// weight_bank_loader: streaming-load weight memory for one layer block.
//   clk, reset : clock, synchronous active-high reset
//   bus        : weight_bank_loader_if slave
//                - word stream loads node 0..LAYER_SIZE-1 of layer 0, then layer 1, ...
//                - read port returns all lanes of one layer, one cycle after rd_en
// The load FSM and counters live here; each lane is a weight_lane instance.
module weight_bank_loader
  import nn_pkg::*;
#(
  parameter int unsigned LAYER_SIZE  = 4,
  parameter int unsigned LAYER_DEPTH = 4,
  parameter int unsigned BIT_SIZE    = BitSize
) (
  input  logic                 clk,
  input  logic                 reset,
  weight_bank_loader_if.slave  bus
);

  localparam int unsigned NodeW  = $clog2(LAYER_SIZE);
  localparam int unsigned LayerW = $clog2(LAYER_DEPTH);
  localparam logic [NodeW-1:0]  NodeLast  = NodeW'(LAYER_SIZE - 1);
  localparam logic [LayerW-1:0] LayerLast = LayerW'(LAYER_DEPTH - 1);

  state_e              r_state;
  logic [NodeW-1:0]    r_node_cnt;
  logic [LayerW-1:0]   r_layer_cnt;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_load_done;
  logic                r_rd_valid;

  logic                                w_accept;
  logic [LAYER_SIZE-1:0]               w_lane_we;
  logic [LAYER_SIZE-1:0][BIT_SIZE-1:0] w_rd_data;

  // r_in_ready is high exactly in StLoad; reset blocks the write of its own cycle.
  assign w_accept = bus.in_valid & r_in_ready & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_node_cnt  <= '0;
      r_layer_cnt <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_state     <= StLoad;
            r_node_cnt  <= '0;
            r_layer_cnt <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        StLoad: begin
          // Restart wins over counter advance; a word accepted now is still written.
          if (bus.start) begin
            r_node_cnt  <= '0;
            r_layer_cnt <= '0;
          end else if (w_accept) begin
            if (r_node_cnt == NodeLast) begin
              r_node_cnt <= '0;
              if (r_layer_cnt == LayerLast) begin
                r_layer_cnt <= '0;
                r_state     <= StDone;
                r_in_ready  <= 1'b0;
                r_load_done <= 1'b1;
              end else begin
                r_layer_cnt <= r_layer_cnt + 1'b1;
              end
            end else begin
              r_node_cnt <= r_node_cnt + 1'b1;
            end
          end
        end
        StDone: begin
          if (bus.start) begin
            r_state     <= StLoad;
            r_node_cnt  <= '0;
            r_layer_cnt <= '0;
            r_in_ready  <= 1'b1;
          end else begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state    <= StIdle;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
    end
  end

  for (genvar i = 0; i < LAYER_SIZE; i++) begin : g_lane
    assign w_lane_we[i] = w_accept & (r_node_cnt == NodeW'(i));

    weight_lane #(
      .Depth (LAYER_DEPTH),
      .Width (BIT_SIZE)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_lane_we[i]),
      .i_waddr (r_layer_cnt),
      .i_wdata (bus.in_data),
      .i_re    (bus.rd_en),
      .i_raddr (bus.rd_layer),
      .o_rdata (w_rd_data[i])
    );
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.load_done = r_load_done;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = w_rd_data;

endmodule

// File: tb/tb_weight_bank_loader.sv
// tb_weight_bank_loader: scoreboard bench for weight_bank_loader (4 lanes x 3 layers x 16 bit).
// A spec-level model of the load FSM and memory runs alongside the DUT; each read
// request pushes the expected layer image, popped when rd_valid appears.
module tb_weight_bank_loader;
  import nn_pkg::*;

  localparam int unsigned LayerSize  = 4;
  localparam int unsigned LayerDepth = 3;
  localparam int unsigned BitW       = 16;

  typedef struct packed {
    logic [LayerSize-1:0][BitW-1:0] data;
    logic [LayerSize-1:0]           known;
  } rd_exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  weight_bank_loader_if #(
    .LAYER_SIZE  (LayerSize),
    .LAYER_DEPTH (LayerDepth),
    .BIT_SIZE    (BitW)
  ) bus ();

  weight_bank_loader #(
    .LAYER_SIZE  (LayerSize),
    .LAYER_DEPTH (LayerDepth),
    .BIT_SIZE    (BitW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  int      st = 0;  // 0 idle, 1 load, 2 done
  int      node_c = 0;
  int      layer_c = 0;
  weight_t mem_m [LayerDepth][LayerSize];
  bit      known_m [LayerDepth][LayerSize];
  bit      rd_exp = 1'b0;
  rd_exp_t sb_q [$];
  int      cyc = 0;
  int      done_seen = 0;
  int      last_done_cyc = 0;
  int      start_cyc = 0;
  bit      last_acc = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model on the inputs being driven.
  task automatic tick();
    rd_exp_t e;
    int      rl;
    @(negedge clk);
    cyc++;
    check("in_ready", 64'(bus.in_ready), 64'(st == 1));
    check("busy", 64'(bus.busy), 64'(st != 0));
    check("load_done", 64'(bus.load_done), 64'(st == 2));
    if (bus.load_done === 1'b1) begin
      done_seen++;
      last_done_cyc = cyc;
    end
    check("rd_valid", 64'(bus.rd_valid), 64'(rd_exp));
    if (rd_exp) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        for (int l = 0; l < LayerSize; l++) begin
          if (e.known[l]) check($sformatf("rd_data_lane%0d", l), 64'(bus.rd_data[l]),
                                64'(e.data[l]));
        end
      end
    end

    rd_exp = bus.rd_en && !reset;
    if (rd_exp) begin
      rl = int'(bus.rd_layer);
      e  = '0;
      for (int l = 0; l < LayerSize; l++) begin
        e.data[l]  = mem_m[rl][l];
        e.known[l] = known_m[rl][l];
      end
      sb_q.push_back(e);
    end

    last_acc = bus.in_valid && (st == 1) && !reset;
    if (last_acc) begin
      mem_m[layer_c][node_c]   = bus.in_data;
      known_m[layer_c][node_c] = 1'b1;
    end
    if (reset) begin
      st = 0; node_c = 0; layer_c = 0;
    end else begin
      case (st)
        0: if (bus.start) begin st = 1; node_c = 0; layer_c = 0; end
        1: begin
          if (bus.start) begin
            node_c = 0; layer_c = 0;
          end else if (last_acc) begin
            if (node_c == LayerSize - 1) begin
              node_c = 0;
              if (layer_c == LayerDepth - 1) begin
                layer_c = 0;
                st = 2;
              end else begin
                layer_c++;
              end
            end else begin
              node_c++;
            end
          end
        end
        default: begin
          if (bus.start) begin st = 1; node_c = 0; layer_c = 0; end
          else st = 0;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic load_words(input int n, input logic [BitW-1:0] base, input int gap_pct);
    int w = 0;
    int guard = 0;
    while (w < n && guard < 400) begin
      bus.in_valid = (int'($urandom_range(99)) >= gap_pct);
      bus.in_data  = BitW'(base + BitW'(w));
      tick();
      guard++;
      if (last_acc) w++;
    end
    bus.in_valid = 1'b0;
    check("load_words_count", 64'(w), 64'(n));
  endtask

  task automatic read_layer(input int l);
    bus.rd_en    = 1'b1;
    bus.rd_layer = 2'(l);
    tick();
    bus.rd_en    = 1'b0;
  endtask

  task automatic read_all();
    for (int l = 0; l < LayerDepth; l++) read_layer(l);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < LayerDepth; a++)
      for (int b = 0; b < LayerSize; b++) begin
        mem_m[a][b]   = '0;
        known_m[a][b] = 1'b0;
      end
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.rd_en    = 1'b0;
    bus.rd_layer = '0;
    @(posedge clk);
    #1;
    repeat (2) tick();
    check("reset_rd_data", 64'(bus.rd_data), 64'd0);
    reset = 1'b0;

    // Idle with in_valid high: nothing accepted, outputs stay 0.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hDEAD;
    repeat (5) tick();
    bus.in_valid = 1'b0;
    check("idle_rd_data", 64'(bus.rd_data), 64'd0);

    // Full load 1..12 with in_valid held high.
    start_cyc = cyc + 1;
    done_seen = 0;
    pulse_start();
    load_words(12, 16'h0001, 0);
    repeat (2) tick();
    check("done_latency", 64'(last_done_cyc - start_cyc), 64'd13);
    check("done_count_full", 64'(done_seen), 64'd1);
    read_layer(1);
    tick();
    read_all();

    // Same load size with random gaps.
    pulse_start();
    load_words(12, 16'h0100, 40);
    repeat (2) tick();
    read_all();

    // Reload 1..12, then collide a read of layer 0 with the write of (0,2).
    pulse_start();
    load_words(12, 16'h0001, 0);
    repeat (2) tick();
    pulse_start();
    load_words(2, 16'hA000, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hBEEF;
    bus.rd_en    = 1'b1;
    bus.rd_layer = 2'd0;
    tick();
    check("collide_accept", 64'(last_acc), 64'd1);
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    tick();
    check("collide_old_lane2", 64'(bus.rd_data[2]), 64'h0003);
    read_layer(0);
    tick();
    check("collide_new_lane2", 64'(bus.rd_data[2]), 64'hBEEF);

    // Restart after 5 accepts, with a word accepted in the restart cycle.
    load_words(2, 16'hA100, 0);
    done_seen    = 0;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hA1FF;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    load_words(12, 16'h0200, 0);
    repeat (2) tick();
    check("done_count_restart", 64'(done_seen), 64'd1);
    read_all();

    // Reset after 7 accepts of a new load.
    pulse_start();
    load_words(7, 16'h0300, 0);
    done_seen    = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h03FF;
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check("reset_no_done", 64'(done_seen), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    read_all();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
